prvp_dc_token_ring_rd_port: RTL and testbench

PRVP_DC_TOKEN_RING_RD_PORT -- requirements
Module: prvp_dc_token_ring_rd_port

---
 rtl/prvp_dc_token_ring_rd_port_pkg.sv | 42 ++++
 rtl/prvp_dc_token_sync.sv | 27 ++
 rtl/prvp_dc_token_ring_rd_port.sv | 105 ++++++++++
 tb/tb_prvp_dc_token_ring_rd_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prvp_dc_token_ring_rd_port_pkg.sv
// Shared constants and helpers for the token-ring read port.
package prvp_dc_token_ring_rd_port_pkg;

  // Widest ring the decode helper supports.
  localparam int unsigned MAX_DEPTH = 64;

  // Write token after reset: slots 0 and 1 set, which decodes to position 0.
  localparam logic [MAX_DEPTH-1:0] TOKEN_RST = 64'h3;

  // Ceiling log2; only used on constant arguments.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) res = i + 1;
    end
    return res;
  endfunction

  // Position is the first set bit whose ring predecessor is clear. This also
  // resolves a 1-hot or 3-hot transient to the leading edge of the run.
  function automatic int unsigned token_to_index(input logic [MAX_DEPTH-1:0] tok,
                                                 input int unsigned depth);
    int unsigned idx;
    int unsigned prev;
    logic found;
    idx   = 0;
    prev  = 0;
    found = 1'b0;
    for (int unsigned j = 0; j < MAX_DEPTH; j++) begin
      if (j < depth && !found) begin
        prev = (j == 0) ? depth - 1 : j - 1;
        if (tok[j] && !tok[prev]) begin
          idx   = j;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prvp_dc_token_sync.sv
// Multi-stage flop chain bringing an asynchronous token into the local clock.
module prvp_dc_token_sync #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the token through the synchroniser chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/prvp_dc_token_ring_rd_port.sv
// Read side of a token-ring clock-domain crossing buffer.
module prvp_dc_token_ring_rd_port
  import prvp_dc_token_ring_rd_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned OUTPUT_REG   = 1,
  parameter int unsigned AE_THRESHOLD = 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [BUFFER_DEPTH-1:0]              write_token,
  input  logic [DATA_WIDTH-1:0]                data_async,
  output logic [BUFFER_DEPTH-1:0]              read_pointer,
  output logic [DATA_WIDTH-1:0]                data,
  output logic                                 valid,
  input  logic                                 ready,
  output logic [clog2(BUFFER_DEPTH+1)-1:0]     level,
  output logic                                 almost_empty
);

  localparam int unsigned D  = BUFFER_DEPTH;
  localparam int unsigned IW = clog2(D);
  localparam int unsigned LW = clog2(D + 1);
  localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESHOLD);

  logic [D-1:0]  ws;
  logic [IW-1:0] p;
  logic [IW-1:0] r_q, r_d;
  logic [D-1:0]  rp_q;
  logic [LW-1:0] p_ext, r_ext, ring_count;
  logic          nonempty;
  logic          pop;

  prvp_dc_token_sync #(
    .WIDTH   (D),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (TOKEN_RST[D-1:0])
  ) u_token_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (write_token),
    .dout (ws)
  );

  assign p        = IW'(token_to_index(64'(ws), D));
  assign nonempty = (p != r_q);
  assign p_ext    = LW'(p);
  assign r_ext    = LW'(r_q);
  assign r_d      = (r_q == IW'(D - 1)) ? '0 : r_q + IW'(1);

  // Occupancy of the ring between read index and synchronised write position.
  always_comb begin
    ring_count = '0;
    if (p_ext >= r_ext) ring_count = p_ext - r_ext;
    else                ring_count = p_ext + LW'(D) - r_ext;
  end

  // Read index and its one-hot image advance together on every ring pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q  <= '0;
      rp_q <= D'(1);
    end else if (pop) begin
      r_q  <= r_d;
      rp_q <= {rp_q[D-2:0], rp_q[D-1]};
    end
  end

  assign read_pointer = rp_q;

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Refill the output register whenever it is empty or being drained.
    assign pop = nonempty & (~valid_q | ready);

    // Output register: load on pop, clear when drained with nothing behind it.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (pop) begin
        valid_q <= 1'b1;
        data_q  <= data_async;
      end else if (ready) begin
        valid_q <= 1'b0;
      end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign level = ring_count + LW'(valid_q);
  end else begin : g_comb
    assign pop   = nonempty & ready;
    assign valid = nonempty;
    assign data  = data_async;
    assign level = ring_count;
  end

  assign almost_empty = (level <= AE_LVL);

endmodule

// File: tb/tb_prvp_dc_token_ring_rd_port.sv
// Directed bench for the token-ring read port at default parameters.
module tb_prvp_dc_token_ring_rd_port;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] write_token;
  logic [9:0] data_async;
  logic [7:0] read_pointer;
  logic [9:0] data;
  logic       valid;
  logic       ready;
  logic [3:0] level;
  logic       almost_empty;

  logic [9:0] mem [8];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prvp_dc_token_ring_rd_port dut (
    .clk          (clk),
    .rstn         (rstn),
    .write_token  (write_token),
    .data_async   (data_async),
    .read_pointer (read_pointer),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .level        (level),
    .almost_empty (almost_empty)
  );

  // Storage mux as seen from the write-side memory.
  always_comb begin
    data_async = '0;
    for (int i = 0; i < 8; i++) if (read_pointer[i]) data_async = mem[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tok_of(input int p);
    logic [7:0] t;
    t = '0;
    t[p % 8] = 1'b1;
    t[(p + 1) % 8] = 1'b1;
    return t;
  endfunction

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    write_token = 8'h03;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) next();
    check_eq("rst_rp", read_pointer, 8'h01);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ae", almost_empty, 1);

    rstn = 1'b1;
    next();
    check_eq("rel_rp", read_pointer, 8'h01);
    check_eq("rel_valid", valid, 0);
    check_eq("rel_level", level, 0);
    check_eq("rel_ae", almost_empty, 1);

    // Latency: token 3 -> 6 -> C with ready low.
    mem[0] = 10'h15A;
    mem[1] = 10'h2C3;
    write_token = 8'h06;
    next();
    check_eq("lat_e1_valid", valid, 0);
    write_token = 8'h0C;
    next();
    check_eq("lat_e2_valid", valid, 0);
    check_eq("lat_e2_level", level, 1);
    next();
    check_eq("lat_e3_valid", valid, 1);
    check_eq("lat_e3_data", data, 10'h15A);
    check_eq("lat_e3_level", level, 2);
    check_eq("lat_e3_ae", almost_empty, 0);
    check_eq("lat_e3_rp", read_pointer, 8'h02);

    // Fill to seven entries while stalled.
    for (int i = 2; i < 7; i++) begin
      mem[i] = 10'(10'h040 + i * 10'h031);
      write_token = tok_of(i + 1);
      next();
    end
    repeat (3) next();
    check_eq("fill_level", level, 7);
    check_eq("fill_valid", valid, 1);
    check_eq("fill_data_held", data, 10'h15A);
    check_eq("fill_rp", read_pointer, 8'h02);

    // Drain with ready held high.
    ready = 1'b1;
    for (int k = 1; k < 7; k++) begin
      next();
      check_eq($sformatf("drain%0d_data", k), data, mem[k]);
      check_eq($sformatf("drain%0d_rp", k), read_pointer, 32'(8'h01 << (k + 1)));
      check_eq($sformatf("drain%0d_level", k), level, 7 - k);
      check_eq($sformatf("drain%0d_ae", k), almost_empty, (7 - k) <= 1);
    end
    next();
    check_eq("drain_end_valid", valid, 0);
    check_eq("drain_end_level", level, 0);
    check_eq("drain_end_rp", read_pointer, 8'h80);

    // Wrap of the read pointer from slot 7 back to slot 0.
    mem[7] = 10'h3E1;
    write_token = 8'h03;
    next();
    check_eq("wrap_a_valid", valid, 0);
    next();
    check_eq("wrap_b_valid", valid, 0);
    check_eq("wrap_b_level", level, 1);
    next();
    check_eq("wrap_c_valid", valid, 1);
    check_eq("wrap_c_data", data, 10'h3E1);
    check_eq("wrap_c_rp", read_pointer, 8'h01);
    check_eq("wrap_c_level", level, 1);
    next();
    check_eq("wrap_d_valid", valid, 0);
    check_eq("wrap_d_level", level, 0);
    check_eq("wrap_d_ae", almost_empty, 1);

    // Backpressure: ready 1,0,1.
    ready = 1'b0;
    mem[0] = 10'h0AB;
    mem[1] = 10'h1CD;
    write_token = 8'h06;
    next();
    write_token = 8'h0C;
    repeat (4) next();
    check_eq("bp_valid", valid, 1);
    check_eq("bp_data", data, 10'h0AB);
    check_eq("bp_level", level, 2);
    ready = 1'b1;
    next();
    check_eq("bp1_data", data, 10'h1CD);
    check_eq("bp1_valid", valid, 1);
    check_eq("bp1_level", level, 1);
    ready = 1'b0;
    next();
    check_eq("bp0_data", data, 10'h1CD);
    check_eq("bp0_valid", valid, 1);
    ready = 1'b1;
    next();
    check_eq("bp2_valid", valid, 0);
    check_eq("bp2_level", level, 0);
    ready = 1'b0;

    // Three visible entries, then reset mid-transfer.
    for (int i = 2; i < 5; i++) begin
      mem[i] = 10'(10'h100 + i);
      write_token = tok_of(i + 1);
      next();
    end
    repeat (3) next();
    check_eq("pre_rst_level", level, 3);
    check_eq("pre_rst_data", data, 10'h102);
    rstn = 1'b0;
    write_token = 8'h03;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_rp", read_pointer, 8'h01);
    next();
    check_eq("in_rst_valid", valid, 0);
    check_eq("in_rst_level", level, 0);
    rstn = 1'b1;
    next();
    check_eq("post_rst_valid", valid, 0);
    check_eq("post_rst_level", level, 0);

    // Transient 3-hot token decodes to position 0; ready while empty is ignored.
    write_token = 8'h07;
    ready = 1'b1;
    repeat (4) next();
    check_eq("t7_valid", valid, 0);
    check_eq("t7_level", level, 0);
    check_eq("t7_rp", read_pointer, 8'h01);
    ready = 1'b0;

    // Transient 1-hot token decodes to position 2.
    write_token = 8'h04;
    repeat (4) next();
    check_eq("t4_valid", valid, 1);
    check_eq("t4_data", data, 10'h0AB);
    check_eq("t4_level", level, 2);
    check_eq("t4_rp", read_pointer, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
